// File: rtl/float_to_int_pipe.sv
// Three-stage float to signed integer converter with valid/ready handshake.
// S1 unpacks and classifies the float and aligns the significand into an
// INT_W+2 bit window {integer, guard, sticky}; S2 right-shifts that window
// with sticky jamming; S3 rounds, negates, saturates and produces the flags.
// All stages advance together whenever the output register can accept data.
module float_to_int_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic                   in_rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INT_W-1:0]       out_int,
    output logic                   out_ovf,
    output logic                   out_inexact,
    output logic                   out_invalid
);

    // Window: [W-1:2] integer bits, [1] guard, [0] sticky.
    localparam int W    = INT_W + 2;
    localparam int SH_W = $clog2(INT_W);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;

    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    logic enable;

    // ---------------- Stage 1: unpack / classify / unbias ----------------
    logic                        in_sign;
    logic [EXP_W-1:0]            in_exp;
    logic [MAN_W-1:0]            in_man;
    logic signed [EXP_W+1:0]     e_unb;
    logic [MAN_W+INT_W-1:0]      man_ext;
    logic [W-1:0]                a_norm;
    logic [W-1:0]                s1_a_next;
    logic [SH_W-1:0]             s1_sh_next;
    logic                        s1_fovf_next;
    logic                        s1_nan_next;

    logic                        s1_valid_reg;
    logic                        s1_sign_reg;
    logic                        s1_rnd_reg;
    logic [W-1:0]                s1_a_reg;
    logic [SH_W-1:0]             s1_sh_reg;
    logic                        s1_fovf_reg;
    logic                        s1_nan_reg;

    assign in_sign = in_data[EXP_W+MAN_W];
    assign in_exp  = in_data[MAN_W +: EXP_W];
    assign in_man  = in_data[MAN_W-1:0];
    assign e_unb   = $signed({2'b00, in_exp}) - $signed((EXP_W+2)'(BIAS));

    // Significand with the hidden 1 placed at weight 2^(INT_W-1); mantissa
    // bits that do not fit in the window collapse into the sticky bit.
    assign man_ext = {in_man, {INT_W{1'b0}}};
    assign a_norm  = {1'b1, man_ext[MAN_W+INT_W-1 -: INT_W], |man_ext[MAN_W-1:0]};

    // Classification; magnitudes below one reuse the shifter with shift 0,
    // and overflow is decided from the exponent so the window never grows.
    always_comb begin
        s1_a_next    = a_norm;
        s1_sh_next   = SH_W'(INT_W - 1) - e_unb[SH_W-1:0];
        s1_fovf_next = 1'b0;
        s1_nan_next  = 1'b0;
        if (in_exp == '1) begin
            s1_a_next    = '0;
            s1_sh_next   = '0;
            s1_nan_next  = (in_man != '0);
            s1_fovf_next = (in_man == '0);
        end else if (in_exp == '0) begin
            s1_a_next  = W'({1'b0, in_man != '0});
            s1_sh_next = '0;
        end else if (e_unb[EXP_W+1]) begin
            s1_a_next  = (e_unb == '1) ? W'({1'b1, in_man != '0}) : W'(2'b01);
            s1_sh_next = '0;
        end else if (e_unb >= $signed((EXP_W+2)'(INT_W))) begin
            s1_a_next    = '0;
            s1_sh_next   = '0;
            s1_fovf_next = 1'b1;
        end
    end

    // ---------------- Stage 2: barrel shift with sticky -----------------
    logic [W-1:0] s2_r_next;

    logic         s2_valid_reg;
    logic         s2_sign_reg;
    logic         s2_rnd_reg;
    logic [W-1:0] s2_r_reg;
    logic         s2_fovf_reg;
    logic         s2_nan_reg;

    // Logarithmic right shifter; every bit shifted out is ORed into bit 0.
    always_comb begin
        s2_r_next = s1_a_reg;
        for (int k = 0; k < SH_W; k++) begin
            if (s1_sh_reg[k]) begin
                s2_r_next = (s2_r_next >> (1 << k))
                          | W'(|(s2_r_next & ((W'(1) << (1 << k)) - W'(1))));
            end
        end
    end

    // ---------------- Stage 3: round / negate / saturate ----------------
    logic [INT_W-1:0] mag;
    logic             guard_bit;
    logic             sticky_bit;
    logic             round_inc;
    logic [INT_W:0]   mag_r;
    logic             pos_ovf;
    logic             neg_ovf;
    logic             ovf_any;
    logic [INT_W-1:0] signed_val;
    logic [INT_W-1:0] out_int_next;
    logic             out_ovf_next;
    logic             out_inexact_next;
    logic             out_invalid_next;

    logic             out_valid_reg;
    logic [INT_W-1:0] out_int_reg;
    logic             out_ovf_reg;
    logic             out_inexact_reg;
    logic             out_invalid_reg;

    // Round-to-nearest-even increment, then range check on the signed value.
    always_comb begin
        mag              = s2_r_reg[W-1:2];
        guard_bit        = s2_r_reg[1];
        sticky_bit       = s2_r_reg[0];
        round_inc        = s2_rnd_reg & guard_bit & (sticky_bit | mag[0]);
        mag_r            = {1'b0, mag} + {{INT_W{1'b0}}, round_inc};
        pos_ovf          = mag_r[INT_W] | mag_r[INT_W-1];
        neg_ovf          = mag_r[INT_W] | (mag_r[INT_W-1] & (|mag_r[INT_W-2:0]));
        ovf_any          = s2_fovf_reg | s2_nan_reg | (s2_sign_reg ? neg_ovf : pos_ovf);
        signed_val       = s2_sign_reg ? (INT_W'(0) - mag_r[INT_W-1:0]) : mag_r[INT_W-1:0];
        out_int_next     = signed_val;
        if (s2_nan_reg) begin
            out_int_next = INT_MAX;
        end else if (ovf_any) begin
            out_int_next = s2_sign_reg ? INT_MIN : INT_MAX;
        end
        out_ovf_next     = ovf_any;
        out_inexact_next = (guard_bit | sticky_bit) & ~ovf_any;
        out_invalid_next = s2_nan_reg;
    end

    assign enable   = ~out_valid_reg | out_ready;
    assign in_ready = enable;

    // Pipeline registers: reset clears everything, otherwise all stages
    // (including bubbles) advance together on enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg    <= 1'b0;
            s1_sign_reg     <= 1'b0;
            s1_rnd_reg      <= 1'b0;
            s1_a_reg        <= '0;
            s1_sh_reg       <= '0;
            s1_fovf_reg     <= 1'b0;
            s1_nan_reg      <= 1'b0;
            s2_valid_reg    <= 1'b0;
            s2_sign_reg     <= 1'b0;
            s2_rnd_reg      <= 1'b0;
            s2_r_reg        <= '0;
            s2_fovf_reg     <= 1'b0;
            s2_nan_reg      <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_int_reg     <= '0;
            out_ovf_reg     <= 1'b0;
            out_inexact_reg <= 1'b0;
            out_invalid_reg <= 1'b0;
        end else if (enable) begin
            s1_valid_reg  <= in_valid;
            s1_sign_reg   <= in_sign;
            s1_rnd_reg    <= in_rnd;
            s1_a_reg      <= s1_a_next;
            s1_sh_reg     <= s1_sh_next;
            s1_fovf_reg   <= s1_fovf_next;
            s1_nan_reg    <= s1_nan_next;
            s2_valid_reg  <= s1_valid_reg;
            s2_sign_reg   <= s1_sign_reg;
            s2_rnd_reg    <= s1_rnd_reg;
            s2_r_reg      <= s2_r_next;
            s2_fovf_reg   <= s1_fovf_reg;
            s2_nan_reg    <= s1_nan_reg;
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_int_reg     <= out_int_next;
                out_ovf_reg     <= out_ovf_next;
                out_inexact_reg <= out_inexact_next;
                out_invalid_reg <= out_invalid_next;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_int     = out_int_reg;
    assign out_ovf     = out_ovf_reg;
    assign out_inexact = out_inexact_reg;
    assign out_invalid = out_invalid_reg;

endmodule

// File: tb/tb_float_to_int_pipe.sv
// Bench for float_to_int_pipe (default float32 -> int32): directed corner
// values, a randomly stalled stream against an arithmetic reference model,
// and reset behaviour with samples in flight.
module tb_float_to_int_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_rnd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_int;
    logic        out_ovf;
    logic        out_inexact;
    logic        out_invalid;
    logic [34:0] obs;

    int total = 0;
    int bad = 0;

    assign obs = {out_int, out_ovf, out_inexact, out_invalid};

    float_to_int_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_rnd     (in_rnd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_int    (out_int),
        .out_ovf    (out_ovf),
        .out_inexact(out_inexact),
        .out_invalid(out_invalid)
    );

    always #5 clk = ~clk;

    // Reference: exact value = M * 2^(e-23); integer part and remainder are
    // computed directly and rounding compares the remainder with one half.
    function automatic logic [34:0] ref_model(input logic [31:0] d, input logic rnd);
        int     ex, e, shf;
        longint m, ival, rem, half, val;
        logic   inx;
        ex = int'(d[30:23]);
        if (ex == 255) begin
            if (d[22:0] != 0) return {32'h7FFFFFFF, 3'b101};
            return {(d[31] ? 32'h80000000 : 32'h7FFFFFFF), 3'b100};
        end
        if (ex == 0) return {32'd0, 1'b0, (d[22:0] != 0), 1'b0};
        e    = ex - 127;
        m    = 64'sd8388608 + longint'(d[22:0]);
        inx  = 1'b0;
        if (e >= 40) begin
            ival = 64'sd1 <<< 40;
        end else if (e >= 23) begin
            ival = m <<< (e - 23);
        end else if (e < -40) begin
            ival = 0;
            inx  = 1'b1;
        end else begin
            shf  = 23 - e;
            ival = m >>> shf;
            rem  = m - (ival <<< shf);
            half = 64'sd1 <<< (shf - 1);
            inx  = (rem != 0);
            if (rnd && ((rem > half) || ((rem == half) && ival[0]))) ival = ival + 1;
        end
        val = d[31] ? -ival : ival;
        if (val > 64'sd2147483647) return {32'h7FFFFFFF, 3'b100};
        if (val < -64'sd2147483648) return {32'h80000000, 3'b100};
        return {val[31:0], 1'b0, inx, 1'b0};
    endfunction

    // Push one sample into an idle pipeline and wait for its result.
    task automatic send_one(input logic [31:0] d, input logic r, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_rnd    = r;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || obs !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs valid=%b obs=%h want valid=0 obs=0", out_valid, obs);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            total++;
            if (seen != 0) begin
                bad++;
                $display("FAIL reset_ignores_in_valid results_seen=%0d want=0", seen);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_directed();
        logic [31:0] td [0:13];
        logic        tr [0:13];
        logic [34:0] te [0:13];
        int          lat;
        td = '{32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'hC0200000, 32'h4F000000,
               32'hCF000000, 32'h7FC00000, 32'h3F000000, 32'h00000001, 32'h80000000,
               32'hFF800000, 32'hBF7FFFFF, 32'h4EFFFFFF, 32'hDF000000};
        tr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b0};
        te = '{{32'h00000001, 3'b000}, {32'h00000001, 3'b010}, {32'h00000002, 3'b010},
               {32'hFFFFFFFE, 3'b010}, {32'h7FFFFFFF, 3'b100}, {32'h80000000, 3'b000},
               {32'h7FFFFFFF, 3'b101}, {32'h00000000, 3'b010}, {32'h00000000, 3'b010},
               {32'h00000000, 3'b000}, {32'h80000000, 3'b100}, {32'hFFFFFFFF, 3'b010},
               {32'h7FFFFF80, 3'b000}, {32'h80000000, 3'b100}};
        for (int i = 0; i < 14; i++) begin
            send_one(td[i], tr[i], lat);
            $display("directed in=%h rnd=%b lat=%0d out=%h ovf=%b inx=%b inv=%b",
                     td[i], tr[i], lat, out_int, out_ovf, out_inexact, out_invalid);
            total++;
            if (lat != 3) begin
                bad++;
                $display("FAIL latency in=%h got=%0d want=3", td[i], lat);
            end
            total++;
            if (obs !== te[i]) begin
                bad++;
                $display("FAIL directed in=%h rnd=%b got=%h want=%h", td[i], tr[i], obs, te[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [34:0] exp_q[$];
        logic [34:0] want;
        logic [34:0] held = '0;
        logic        stall_prev = 1'b0;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        localparam int N = 24;
        @(negedge clk);
        while (got < N && cyc < 3000) begin
            if (stall_prev) begin
                total++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    bad++;
                    $display("FAIL stall_stable valid=%b got=%h want=%h", out_valid, obs, held);
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       in_data = $urandom;
                1:       in_data = {1'($urandom), ($urandom_range(0, 1) ? 8'hFF : 8'h00),
                                    ($urandom_range(0, 1) ? 23'($urandom) : 23'd0)};
                default: in_data = {1'($urandom), 8'($urandom_range(110, 160)), 23'($urandom)};
            endcase
            in_rnd = 1'($urandom);
            #1;
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("FAIL in_ready got=%b want=%b", in_ready, (!out_valid || out_ready));
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra got=%h want=none", obs);
                end else begin
                    want = exp_q.pop_front();
                    $display("stream result %0d out=%h want=%h", got, obs, want);
                    if (obs !== want) begin
                        bad++;
                        $display("FAIL stream_result idx=%0d got=%h want=%h", got, obs, want);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_data, in_rnd));
                sent++;
            end
            stall_prev = out_valid && !out_ready;
            held       = obs;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != N || sent != N || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stream_count sent=%0d got=%0d left=%0d want=%0d", sent, got,
                     exp_q.size(), N);
        end
        begin
            int extra = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (out_valid) extra++;
            end
            total++;
            if (extra != 0) begin
                bad++;
                $display("FAIL stream_duplicate extra=%0d want=0", extra);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h40400000 + 32'(i) * 32'h00800000;
            in_rnd   = 1'b0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || obs !== 35'd0) begin
            bad++;
            $display("FAIL inflight_reset valid=%b obs=%h want valid=0 obs=0", out_valid, obs);
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL inflight_discard results_seen=%0d want=0", seen);
        end
        $display("test_reset_inflight done seen=%0d", seen);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
